// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types and constants.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/if_wb.sv
// Classic Wishbone bus bundle: 32-bit data, 4 byte selects, parameterised address.
interface if_wb #(
  parameter int unsigned AWIDTH = 25
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [AWIDTH-1:0] adr;
  logic [31:0]       dat_o;
  logic [31:0]       dat_i;
  logic              ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack
  );

endinterface

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive stalled strobe cycles and flags when TIMEOUT is reached.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stall,
  output logic o_fire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  assign o_fire = (r_count == CW'(TIMEOUT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (o_fire || !i_stall) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with whole-cycle bus lock and stall watchdog.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int unsigned AWIDTH  = 25,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_wb.slave         m0,
  if_wb.slave         m1,
  if_wb.master        sbus,
  output logic        timeout_o,
  output logic [1:0]  grant_o
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_last_owner;
  logic              r_timeout;
  logic              w_stall;
  logic              w_wd_fire;
  logic              w_fire;
  logic [AWIDTH-1:0] w_adr;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_stall (w_stall),
    .o_fire  (w_wd_fire)
  );

  // The counter can sit at TIMEOUT for one IDLE cycle after a release, so gate by ownership.
  assign w_fire    = w_wd_fire && (r_state != IDLE);
  assign timeout_o = r_timeout;
  assign sbus.adr  = w_adr;

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      OWN0:    w_stall = m0.stb && !sbus.ack;
      OWN1:    w_stall = m1.stb && !sbus.ack;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == OWN0 && !m0.cyc) r_last_owner <= 1'b0;
      if (r_state == OWN1 && !m1.cyc) r_last_owner <= 1'b1;
      if (w_fire)                     r_timeout    <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) w_next = r_last_owner ? OWN0 : OWN1;
        else if (m0.cyc)      w_next = OWN0;
        else if (m1.cyc)      w_next = OWN1;
      end
      OWN0:    if (!m0.cyc) w_next = IDLE;
      OWN1:    if (!m1.cyc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    grant_o    = 2'b00;
    sbus.cyc   = 1'b0;
    sbus.stb   = 1'b0;
    sbus.we    = 1'b0;
    sbus.sel   = '0;
    w_adr      = '0;
    sbus.dat_o = '0;
    m0.ack     = 1'b0;
    m0.dat_i   = '0;
    m1.ack     = 1'b0;
    m1.dat_i   = '0;
    case (r_state)
      OWN0: begin
        grant_o    = 2'b01;
        sbus.cyc   = m0.cyc;
        sbus.stb   = m0.stb && !w_fire;
        sbus.we    = m0.we;
        sbus.sel   = m0.sel;
        w_adr      = m0.adr;
        sbus.dat_o = m0.dat_o;
        m0.ack     = sbus.ack || w_fire;
        m0.dat_i   = w_fire ? WB_TIMEOUT_DATA : sbus.dat_i;
      end
      OWN1: begin
        grant_o    = 2'b10;
        sbus.cyc   = m1.cyc;
        sbus.stb   = m1.stb && !w_fire;
        sbus.we    = m1.we;
        sbus.sel   = m1.sel;
        w_adr      = m1.adr;
        sbus.dat_o = m1.dat_o;
        m1.ack     = sbus.ack || w_fire;
        m1.dat_i   = w_fire ? WB_TIMEOUT_DATA : sbus.dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic against a reference model.
module tb_wb_arbiter2;

  localparam int unsigned AW = 25;
  localparam int          TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       timeout_o;
  logic [1:0] grant_o;

  if_wb #(.AWIDTH(AW)) m0_if ();
  if_wb #(.AWIDTH(AW)) m1_if ();
  if_wb #(.AWIDTH(AW)) sbus_if ();

  wb_arbiter2 #(
    .AWIDTH  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .sbus      (sbus_if),
    .timeout_o (timeout_o),
    .grant_o   (grant_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner (-1 = nobody), who was served last, consecutive stalled cycles, sticky flag.
  int mo_owner;
  int mo_last;
  int mo_stall;
  bit mo_tflag;

  function automatic bit mcyc(int k);
    return (k == 0) ? m0_if.cyc : m1_if.cyc;
  endfunction

  function automatic bit mstb(int k);
    return (k == 0) ? m0_if.stb : m1_if.stb;
  endfunction

  function automatic bit exp_fire();
    return (mo_owner >= 0) && (mo_stall == TO);
  endfunction

  function automatic logic [63:0] mreq(int k);
    if (k == 0) return {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.adr, m0_if.dat_o};
    return {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.adr, m1_if.dat_o};
  endfunction

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = 1;
    mo_stall = 0;
    mo_tflag = 0;
  endtask

  // Advance the model over the coming clock edge using the inputs currently applied.
  task automatic tick();
    bit f;
    bit stalled;
    f = exp_fire();
    if (mo_owner >= 0) begin
      stalled  = mstb(mo_owner) && !sbus_if.ack;
      if (f) mo_tflag = 1;
      mo_stall = (f || !stalled) ? 0 : mo_stall + 1;
      if (!mcyc(mo_owner)) begin
        mo_last  = mo_owner;
        mo_owner = -1;
      end
    end else begin
      mo_stall = 0;
      if (m0_if.cyc && m1_if.cyc) mo_owner = 1 - mo_last;
      else if (m0_if.cyc)         mo_owner = 0;
      else if (m1_if.cyc)         mo_owner = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(int k, bit cyc, bit we, logic [AW-1:0] adr, logic [31:0] dat);
    if (k == 0) begin
      m0_if.cyc = cyc; m0_if.stb = cyc; m0_if.we = we; m0_if.sel = 4'hF;
      m0_if.adr = adr; m0_if.dat_o = dat;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = cyc; m1_if.we = we; m1_if.sel = 4'hF;
      m1_if.adr = adr; m1_if.dat_o = dat;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack   = 1'b0;
    sbus_if.dat_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m(0, 1, 0, 25'h10, '0);
    set_m(1, 1, 0, 25'h20, '0);
    sbus_if.ack = 1'b1;
    @(posedge clk);
    #2;
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    n_vec++; if (sbus_if.cyc !== 1'b0 || sbus_if.stb !== 1'b0 || sbus_if.we !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got cyc/stb/we %b%b%b want 000", sbus_if.cyc, sbus_if.stb, sbus_if.we); end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    n_vec++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin
      n_err++; $display("FAIL reset_ack: got m0 %b m1 %b want 0 0", m0_if.ack, m1_if.ack); end
    do_reset();
  endtask

  task automatic test_single_read();
    set_m(0, 1, 0, 25'h0000100, '0);
    #2;
    n_vec++; if (sbus_if.cyc !== 1'b0) begin n_err++; $display("FAIL read_latency0: got sbus.cyc %b want 0", sbus_if.cyc); end
    tick(); #2;
    n_vec++; if (sbus_if.cyc !== 1'b1 || grant_o !== 2'b01 || sbus_if.adr !== 25'h100) begin
      n_err++; $display("FAIL read_grant: got cyc %b grant %b adr %h want 1 01 0000100", sbus_if.cyc, grant_o, sbus_if.adr); end
    tick();
    tick();
    sbus_if.ack = 1'b1; sbus_if.dat_i = 32'hDEADBEEF;
    #2;
    n_vec++; if (m0_if.ack !== 1'b1 || m0_if.dat_i !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL read_data: got ack %b dat %h want 1 deadbeef", m0_if.ack, m0_if.dat_i); end
    n_vec++; if (m1_if.ack !== 1'b0 || m1_if.dat_i !== 32'h0) begin
      n_err++; $display("FAIL read_nonowner: got m1 ack %b dat %h want 0 00000000", m1_if.ack, m1_if.dat_i); end
    tick();
    set_m(0, 0, 0, '0, '0);
    sbus_if.ack = 1'b0; sbus_if.dat_i = '0;
    tick(); #2;
    n_vec++; if (grant_o !== 2'b00 || sbus_if.adr !== '0) begin
      n_err++; $display("FAIL read_release: got grant %b adr %h want 00 0", grant_o, sbus_if.adr); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_m(0, 1, 0, 25'h111, '0);
    set_m(1, 1, 1, 25'h222, 32'h5555AAAA);
    #2;
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rr_idle: got %b want 00", grant_o); end
    tick(); #2;
    n_vec++; if (grant_o !== 2'b01 || sbus_if.adr !== 25'h111) begin
      n_err++; $display("FAIL rr_first_tie: got grant %b adr %h want 01 0000111", grant_o, sbus_if.adr); end
    sbus_if.ack = 1'b1;
    tick();
    set_m(0, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick(); #2;
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rr_gap: got %b want 00", grant_o); end
    tick(); #2;
    n_vec++; if (grant_o !== 2'b10 || sbus_if.adr !== 25'h222 || sbus_if.dat_o !== 32'h5555AAAA || sbus_if.we !== 1'b1) begin
      n_err++; $display("FAIL rr_second: got grant %b adr %h dat %h we %b want 10 0000222 5555aaaa 1",
                        grant_o, sbus_if.adr, sbus_if.dat_o, sbus_if.we); end
    sbus_if.ack = 1'b1;
    tick();
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick();
    set_m(0, 1, 0, 25'h333, '0);
    set_m(1, 1, 0, 25'h444, '0);
    tick(); #2;
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL rr_second_tie: got %b want 01", grant_o); end
    sbus_if.ack = 1'b1;
    tick();
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_burst_lock();
    set_m(0, 1, 1, 25'h1000, 32'h0);
    tick();
    set_m(1, 1, 0, 25'h2000, '0);
    for (int b = 0; b < 4; b++) begin
      m0_if.adr   = 25'h1000 + 25'(b);
      m0_if.dat_o = 32'(b);
      sbus_if.ack = 1'b1;
      #2;
      n_vec++; if (grant_o !== 2'b01 || sbus_if.adr !== 25'h1000 + 25'(b) || m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin
        n_err++; $display("FAIL burst_beat%0d: got grant %b adr %h ack0 %b ack1 %b want 01 %h 1 0",
                          b, grant_o, sbus_if.adr, m0_if.ack, m1_if.ack, 25'h1000 + 25'(b)); end
      tick();
    end
    set_m(0, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    #2;
    n_vec++; if (grant_o !== 2'b01 || sbus_if.cyc !== 1'b0) begin
      n_err++; $display("FAIL burst_release: got grant %b cyc %b want 01 0", grant_o, sbus_if.cyc); end
    tick(); #2;
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL burst_gap: got %b want 00", grant_o); end
    tick(); #2;
    n_vec++; if (grant_o !== 2'b10 || sbus_if.adr !== 25'h2000) begin
      n_err++; $display("FAIL burst_handover: got grant %b adr %h want 10 0002000", grant_o, sbus_if.adr); end
    sbus_if.ack = 1'b1;
    tick();
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    set_m(1, 1, 1, 25'h0ABCDE, 32'h12345678);
    tick();
    for (int k = 0; k <= TO; k++) begin
      #2;
      n_vec++; if (m1_if.ack !== (k == TO)) begin
        n_err++; $display("FAIL wd_ack_cycle%0d: got %b want %b", k, m1_if.ack, (k == TO)); end
      if (k == TO) begin
        n_vec++; if (m1_if.dat_i !== 32'hFFFFFFFF || sbus_if.stb !== 1'b0 || timeout_o !== 1'b0) begin
          n_err++; $display("FAIL wd_fire: got dat %h stb %b flag %b want ffffffff 0 0",
                            m1_if.dat_i, sbus_if.stb, timeout_o); end
      end
      tick();
    end
    set_m(1, 0, 0, '0, '0);
    #2;
    n_vec++; if (timeout_o !== 1'b1 || m1_if.ack !== 1'b0) begin
      n_err++; $display("FAIL wd_flag: got flag %b ack %b want 1 0", timeout_o, m1_if.ack); end
    tick();
    tick(); #2;
    n_vec++; if (timeout_o !== 1'b1 || grant_o !== 2'b00) begin
      n_err++; $display("FAIL wd_sticky: got flag %b grant %b want 1 00", timeout_o, grant_o); end
  endtask

  task automatic test_reset_mid();
    set_m(1, 1, 0, 25'h777, '0);
    tick();
    tick(); #2;
    n_vec++; if (grant_o !== 2'b10 || sbus_if.stb !== 1'b1) begin
      n_err++; $display("FAIL rstmid_owned: got grant %b stb %b want 10 1", grant_o, sbus_if.stb); end
    rst = 1'b1;
    set_m(0, 1, 0, 25'h888, '0);
    #1;
    n_vec++; if (sbus_if.cyc !== 1'b0 || grant_o !== 2'b00 || m1_if.ack !== 1'b0 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_abort: got cyc %b grant %b ack1 %b flag %b want 0 00 0 0",
                        sbus_if.cyc, grant_o, m1_if.ack, timeout_o); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(); #2;
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL rstmid_tie: got %b want 01", grant_o); end
    sbus_if.ack = 1'b1;
    tick();
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    bit          c0 = 0;
    bit          c1 = 0;
    bit          f;
    int          o;
    logic [1:0]  e_grant;
    logic [63:0] e_req;
    logic [32:0] e_rsp0;
    logic [32:0] e_rsp1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) c0 = !c0;
      if ($urandom_range(0, 5) == 0) c1 = !c1;
      m0_if.cyc = c0; m0_if.stb = c0 && ($urandom_range(0, 3) != 0);
      m0_if.we = 1'($urandom); m0_if.sel = 4'($urandom); m0_if.adr = AW'($urandom); m0_if.dat_o = $urandom;
      m1_if.cyc = c1; m1_if.stb = c1 && ($urandom_range(0, 3) != 0);
      m1_if.we = 1'($urandom); m1_if.sel = 4'($urandom); m1_if.adr = AW'($urandom); m1_if.dat_o = $urandom;
      sbus_if.ack   = ((c / 60) % 2 == 0) && ($urandom_range(0, 2) == 0);
      sbus_if.dat_i = $urandom;
      #2;
      o = mo_owner;
      f = exp_fire();
      e_grant = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
      e_req   = (o >= 0) ? mreq(o) : '0;
      if (f) e_req[62] = 1'b0;
      e_rsp0  = (o == 0) ? {sbus_if.ack || f, f ? 32'hFFFFFFFF : sbus_if.dat_i} : '0;
      e_rsp1  = (o == 1) ? {sbus_if.ack || f, f ? 32'hFFFFFFFF : sbus_if.dat_i} : '0;
      n_vec++; if (grant_o !== e_grant) begin
        n_err++; $display("FAIL rnd_grant@%0d: got %b want %b", c, grant_o, e_grant); end
      n_vec++; if ({sbus_if.cyc, sbus_if.stb, sbus_if.we, sbus_if.sel, sbus_if.adr, sbus_if.dat_o} !== e_req) begin
        n_err++; $display("FAIL rnd_sbus@%0d: got %h want %h", c,
                          {sbus_if.cyc, sbus_if.stb, sbus_if.we, sbus_if.sel, sbus_if.adr, sbus_if.dat_o}, e_req); end
      n_vec++; if ({m0_if.ack, m0_if.dat_i} !== e_rsp0) begin
        n_err++; $display("FAIL rnd_m0rsp@%0d: got %h want %h", c, {m0_if.ack, m0_if.dat_i}, e_rsp0); end
      n_vec++; if ({m1_if.ack, m1_if.dat_i} !== e_rsp1) begin
        n_err++; $display("FAIL rnd_m1rsp@%0d: got %h want %h", c, {m1_if.ack, m1_if.dat_i}, e_rsp1); end
      n_vec++; if (timeout_o !== mo_tflag) begin
        n_err++; $display("FAIL rnd_timeout@%0d: got %b want %b", c, timeout_o, mo_tflag); end
      tick();
    end
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    sbus_if.ack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within the time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter AWIDTH, default 25, meaning address width of all three bus ports (matches the SDRAM cache slave port).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning the number of stalled strobe cycles before the watchdog terminates a transfer.
REQ-003 SHALL have port clk_i, input, 1, meaning the single system clock.
REQ-004 SHALL have port rst_i, input, 1, meaning reset (asynchronous, active-high).
REQ-005 SHALL have port m0, if_wb.slave, AWIDTH/32, meaning the priority-equal master 0 (CPU).
REQ-006 SHALL have port m1, if_wb.slave, AWIDTH/32, meaning the priority-equal master 1 (DMA/video).
REQ-007 SHALL have port sbus, if_wb.master, AWIDTH/32, meaning the shared downstream bus that feeds the cached SDRAM controller's bus port.
REQ-008 SHALL have port timeout_o, output, 1, meaning a sticky watchdog-fired flag.
REQ-009 SHALL have port grant_o, output, 2, meaning one-hot current owner (00 = idle).

Function
REQ-010 SHALL implement FSM states IDLE, OWN0 and OWN1, registered on clk_i.
REQ-011 From IDLE with only mN.cyc high, SHALL enter OWNN on the next edge.
REQ-012 From IDLE with both cyc high, SHALL grant the master not served last (round-robin); last_owner resets to 1 so m0 wins the first tie.
REQ-013 SHALL hold OWNN while mN.cyc is high, regardless of the other master (bus lock for whole cycle, incl. burst/RMW).
REQ-014 SHALL return from OWNN to IDLE on the edge where mN.cyc is sampled low and update last_owner=N; no direct OWN0->OWN1 transfer.
REQ-015 Minimum request-to-sbus.cyc latency SHALL be 1 clock; handover latency between masters SHALL be 2 clocks (one IDLE cycle).
REQ-016 In OWNN, sbus cyc/stb/we/sel/adr/dat_o SHALL be combinationally driven from mN; mN ack and dat_i SHALL come from sbus.
REQ-017 In IDLE, sbus cyc/stb/we SHALL be 0; adr, sel and dat_o SHALL be 0.
REQ-018 A non-owner SHALL see ack=0 and dat_i=0 at all times.
REQ-019 The watchdog counter SHALL count cycles in OWNN with mN.stb=1 and sbus.ack=0, and clear on any ack, on stb=0, or in IDLE.
REQ-020 When the counter reaches TIMEOUT, the block SHALL:
- assert mN.ack for exactly one cycle with dat_i=32'hFFFFFFFF;
- drop sbus.stb for that cycle;
- set timeout_o;
- clear the counter.
REQ-021 The counter width SHALL be $clog2(TIMEOUT+1); the counter SHALL saturate-free compare with ==.
REQ-022 timeout_o SHALL clear only on reset.
REQ-023 mN.cyc dropping mid-transfer (no ack yet) SHALL still release the grant per REQ-014; a late sbus.ack SHALL be discarded.

Reset
REQ-024 On rst_i=1, asynchronously, the block SHALL set:
- state=IDLE;
- last_owner=1;
- counter=0;
- timeout_o=0;
- grant_o=00;
- all sbus strobes 0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer with no ack to either master.

Structure
REQ-026 The package wb_pkg SHALL hold the state enum arb_state_t and the constant WB_TIMEOUT_DATA=32'hFFFFFFFF.
REQ-027 The watchdog SHALL be a sub-module named wb_watchdog (counter plus fire pulse); the mux logic SHALL remain in wb_arbiter2.

Verification
REQ-028 m0 single read at adr 0x0000100, slave acks after 3 cycles with 0xDEADBEEF -> sbus.cyc rises 1 clk after m0.cyc; m0 gets 0xDEADBEEF; m1 ack stays 0.
REQ-029 m0 and m1 raise cyc on the same edge after reset -> m0 granted first; after m0.cyc drops, 1 IDLE clk, then OWN1; next simultaneous tie -> m0.
REQ-030 m0 holds cyc for a 4-beat burst while m1 requests -> m1 waits all 4 acks plus 1 IDLE clock; no interleaving on sbus.
REQ-031 TIMEOUT=8, slave never acks m1 write -> m1.ack on cycle 8 with dat_i=0xFFFFFFFF, timeout_o=1 and stays 1 afterwards.
REQ-032 rst_i pulsed during OWN1 with stb high -> sbus.cyc=0 immediately, grant_o=00, no ack to m1; next tie grants m0.
